// File: rtl/tw_addr_seq.sv
// ============================================================================
// Module   : tw_addr_seq
// Brief    : Radix-2 DIF FFT butterfly sequencer: address pair + twiddle index.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tw_addr_seq #(
    parameter int LOG2N      = 10,
    parameter int ADDR_WIDTH = 11,
    parameter int STAGE_GAP  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LOG2N-1:0]          addr_a,
    output logic [LOG2N-1:0]          addr_b,
    output logic [ADDR_WIDTH+1:0]     k,
    output logic [$clog2(LOG2N)-1:0]  stage,
    output logic                      last_in_stage,
    output logic                      last
);

    localparam int K_WIDTH = ADDR_WIDTH + 2;
    localparam int SW      = $clog2(LOG2N);
    localparam int JW      = LOG2N - 1;
    localparam int GW      = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
    localparam int KSH     = K_WIDTH - LOG2N;

    localparam logic [SW-1:0]    C_LAST_STAGE = SW'(LOG2N - 1);
    localparam logic [GW-1:0]    C_GAP_LAST   = GW'((STAGE_GAP > 0) ? STAGE_GAP - 1 : 0);
    localparam logic [LOG2N-1:0] C_HALF       = LOG2N'(1) << JW;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state, w_state_nx;
    logic [SW-1:0]        r_stage, w_stage_nx;
    logic [JW-1:0]        r_j, w_j_nx;
    logic [GW-1:0]        r_gap, w_gap_nx;
    logic                 r_valid, w_valid_nx;
    logic                 r_busy, w_busy_nx;
    logic                 r_done, w_done_nx;
    logic                 w_load;

    logic [LOG2N-1:0]     r_a, r_b;
    logic [K_WIDTH-1:0]   r_k;
    logic [SW-1:0]        r_d_stage;
    logic                 r_lis, r_last;

    logic [LOG2N-1:0]     w_span, w_m, w_jx, w_p, w_a, w_b;
    logic [K_WIDTH-1:0]   w_k;
    logic                 w_lis, w_last;
    logic                 w_j_end, w_stage_end;

    assign w_j_end     = &r_j;
    assign w_stage_end = (r_stage == C_LAST_STAGE);

    always_comb begin
        w_state_nx = r_state;
        w_stage_nx = r_stage;
        w_j_nx     = r_j;
        w_gap_nx   = r_gap;
        w_valid_nx = r_valid;
        w_busy_nx  = r_busy;
        w_done_nx  = 1'b0;
        w_load     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nx = S_RUN;
                    w_stage_nx = '0;
                    w_j_nx     = '0;
                    w_busy_nx  = 1'b1;
                end
            end
            S_RUN: begin
                // First cycle after start: the output register is still empty.
                if (!r_valid) begin
                    w_load     = 1'b1;
                    w_valid_nx = 1'b1;
                end else if (out_ready) begin
                    if (!w_j_end) begin
                        w_j_nx = r_j + JW'(1);
                        w_load = 1'b1;
                    end else if (w_stage_end) begin
                        w_state_nx = S_DONE;
                        w_valid_nx = 1'b0;
                        w_busy_nx  = 1'b0;
                        w_done_nx  = 1'b1;
                    end else begin
                        w_stage_nx = r_stage + SW'(1);
                        w_j_nx     = '0;
                        if (STAGE_GAP == 0) begin
                            w_load = 1'b1;
                        end else begin
                            w_state_nx = S_GAP;
                            w_valid_nx = 1'b0;
                            w_gap_nx   = '0;
                        end
                    end
                end
            end
            S_GAP: begin
                // Final idle cycle loads the next stage's first descriptor directly.
                if (r_gap == C_GAP_LAST) begin
                    w_state_nx = S_RUN;
                    w_load     = 1'b1;
                    w_valid_nx = 1'b1;
                end else begin
                    w_gap_nx = r_gap + GW'(1);
                end
            end
            S_DONE: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_span = C_HALF >> w_stage_nx;
        w_m    = w_span - LOG2N'(1);
        w_jx   = LOG2N'(w_j_nx);
        w_p    = w_jx & w_m;
        w_a    = ((w_jx & ~w_m) << 1) | w_p;
        w_b    = w_a | w_span;
        w_k    = K_WIDTH'(w_p << w_stage_nx) << KSH;
        w_lis  = &w_j_nx;
        w_last = w_lis && (w_stage_nx == C_LAST_STAGE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_stage   <= '0;
            r_j       <= '0;
            r_gap     <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_k       <= '0;
            r_d_stage <= '0;
            r_lis     <= 1'b0;
            r_last    <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_stage <= w_stage_nx;
            r_j     <= w_j_nx;
            r_gap   <= w_gap_nx;
            r_valid <= w_valid_nx;
            r_busy  <= w_busy_nx;
            r_done  <= w_done_nx;
            if (w_load) begin
                r_a       <= w_a;
                r_b       <= w_b;
                r_k       <= w_k;
                r_d_stage <= w_stage_nx;
                r_lis     <= w_lis;
                r_last    <= w_last;
            end
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign out_valid     = r_valid;
    assign addr_a        = r_a;
    assign addr_b        = r_b;
    assign k             = r_k;
    assign stage         = r_d_stage;
    assign last_in_stage = r_lis;
    assign last          = r_last;

endmodule

`default_nettype wire

// File: doc/tw_addr_seq.md
Name: tw_addr_seq

Overview:
- Sequencer for the shared-butterfly radix-2 DIF FFT. It drives the twiddle generator and the butterfly data memory.
- For every stage and butterfly it emits the memory address pair (addr_a, addr_b) and the full-circle twiddle index k.
- k feeds w_gen directly, where angle = 2*pi*k / 2^K_WIDTH and W = cos - j*sin.
- Sits between the FFT control FSM (start/done) and the butterfly datapath, which accepts one butterfly per valid/ready handshake.

Parameters:
- LOG2N, 10, log2 of FFT length N. Legal range 2..ADDR_WIDTH+2.
- ADDR_WIDTH, 11, quarter-wave sine LUT address width. Must match w_gen.
- K_WIDTH, ADDR_WIDTH+2, twiddle index width (full circle). Local, derived.
- STAGE_GAP, 4, idle cycles inserted between stages for butterfly pipeline drain. 0 is legal.

Ports:
- clk, input, 1, clock. All logic on the rising edge.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, one-cycle request to run a full FFT. Sampled only in IDLE.
- busy, output, 1, high from the cycle after start is accepted through the cycle of the final accept.
- done, output, 1, one-cycle pulse in the cycle after the final butterfly handshake.
- out_valid, output, 1, butterfly descriptor valid.
- out_ready, input, 1, datapath accepts the descriptor.
- addr_a, output, LOG2N, upper-leg data address.
- addr_b, output, LOG2N, lower-leg data address. Always addr_a + span.
- k, output, K_WIDTH, twiddle index for w_gen.
- stage, output, clog2(LOG2N), current stage, 0-based.
- last_in_stage, output, 1, descriptor is the final butterfly of its stage.
- last, output, 1, descriptor is the final butterfly of the FFT.

Behaviour:
- Reset (async assert, sync deassert by the caller): state = IDLE. All outputs are 0; counters are 0.
- States:
  - IDLE: on start go to RUN with stage = 0 and j = 0.
  - RUN: on each accepted descriptor with j = N/2-1:
    - if stage < LOG2N-1 and STAGE_GAP > 0, go to GAP;
    - if stage < LOG2N-1 and STAGE_GAP = 0, stay in RUN at the next stage;
    - if stage = LOG2N-1, go to DONE.
  - GAP: counts STAGE_GAP cycles with out_valid = 0, then returns to RUN with stage+1 and j = 0.
  - DONE: one cycle, done = 1, busy = 0, then IDLE.
- Handshake:
  - Transfer occurs when out_valid & out_ready at a rising edge.
  - While out_valid = 1 and out_ready = 0, all descriptor outputs are held stable.
  - out_valid never drops without a transfer, except on reset.
- Latency:
  - start sampled at edge T gives out_valid = 1 after edge T+1 with the first descriptor.
  - With out_ready held at 1, one descriptor per cycle within a stage.
- Descriptor arithmetic, with j in 0..N/2-1, span = N >> (stage+1) and m = span-1:
  - p = j & m;
  - addr_a = ((j & ~m) << 1) | p;
  - addr_b = addr_a | span;
  - k = (p << stage) << (K_WIDTH - LOG2N).
  - k < 2^(K_WIDTH-1) always, i.e. quadrants 0 and 1 only.
  - All results are unsigned with no overflow. Truncate to the port width.
- Outputs are registered. The next descriptor is computed combinationally from the next-state counters and loaded on a transfer.
- The last_in_stage and last flags are asserted with the descriptor they describe.
- start while busy, in GAP, or in DONE is ignored with no side effect.
- Reset asserted mid-FFT: immediate return to IDLE. out_valid, busy and done are forced to 0. No partial done is issued.
- Total transfers per run = (N/2)*LOG2N.
- Minimum run length with out_ready = 1: (N/2)*LOG2N + (LOG2N-1)*STAGE_GAP + 2 cycles from start to done.

Test Plan:
- LOG2N = 3, STAGE_GAP = 0, out_ready = 1, single start pulse:
  - stage 0 (a,b,k) = (0,4,0), (1,5,1024), (2,6,2048), (3,7,3072);
  - stage 1 = (0,2,0), (1,3,2048), (4,6,0), (5,7,2048);
  - stage 2 = (0,1,0), (2,3,0), (4,5,0), (6,7,0);
  - 12 consecutive valid cycles, last on the 12th, done one cycle later.
- Same configuration with STAGE_GAP = 4:
  - exactly 4 out_valid = 0 cycles after the 4th and after the 8th descriptors;
  - done at cycle 22 after start.
- Random out_ready back-pressure, LOG2N = 10:
  - descriptors are held stable while stalled;
  - exactly 5120 transfers;
  - sequence identical to the stall-free run; last_in_stage on transfers 512, 1024, ...
- start re-pulsed during RUN and during GAP: no restart and no extra transfers; done pulses once.
- rst asserted asynchronously mid-stage 1 (between clock edges): out_valid, busy and done are 0 immediately. A following start produces stage 0, (a,b,k) = (0,4,0) again.
- LOG2N = 13, ADDR_WIDTH = 11: stage 0, j = 4095 gives k = 4095. Stage 12 gives k = 0 for all butterflies, with addr_b = addr_a + 1.
